latch_bank_wr_ctrl: RTL and testbench
=====================================

# latch_bank_wr_ctrl

Write controller and round-robin arbiter for a bank of cross-coupled-NAND level-sensitive latches. Several requesters share one data bus into the bank. The block grants one requester at a time and drives the shared data lines. It sequences a single latch enable through a setup / open / hold window so that data never changes while any enable is high and no two enables are ever high together. It sits between the requester logic and the gate-level latch bank, and is the only driver of the bank's `clk` (enable) and `d` inputs.

## Interface
- `NREQ`, 4: number of requesters, ≥2.
- `DW`, 8: data width per latch word.
- `NLAT`, 4: number of latch words in the bank, ≥2. `AW = clog2(NLAT)` is a derived localparam.
- `SETUP_CYC`, 1: cycles during which data is driven before the enable rises, ≥1.
- `OPEN_CYC`, 2: cycles the enable stays high, ≥1.
- `HOLD_CYC`, 1: cycles data is held after the enable falls, ≥1.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: reset, synchronous, active-high.
- `req`  in  NREQ: per-requester write request, level.
- `req_addr`  in  NREQ*AW: packed addresses; requester i uses bits `[i*AW +: AW]`.
- `req_data`  in  NREQ*DW: packed data; requester i uses bits `[i*DW +: DW]`.
- `gnt`  out  NREQ: one-hot grant, high for the whole transaction.
- `ack`  out  NREQ: one-cycle completion pulse to the granted requester.
- `err`  out  1: one-cycle pulse, coincident with `ack`, when the address was ≥ NLAT.
- `lat_d`  out  DW: shared data to the latch bank.
- `lat_en`  out  NLAT: per-word latch enables; at most one bit is high.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- The FSM has four states: IDLE, SETUP, OPEN, HOLD. A single down-counter times each phase.
- **IDLE**
  - If any `req` bit is high, select a winner by round robin. The search starts at `ptr`, the index after the last winner.
  - On that edge: capture the winner's addr and data into registers, drive `lat_d` from the data register, set `gnt[w]`, load the counter with SETUP_CYC-1, and go to SETUP.
- **SETUP**
  - `lat_en` is all 0.
  - When the counter reaches 0: go to OPEN and set `lat_en[addr]`. If addr ≥ NLAT, no enable bit is set.
- **OPEN**
  - `lat_en[addr]` is held for exactly OPEN_CYC cycles.
  - Then clear `lat_en` and go to HOLD.
- **HOLD**
  - `lat_en` is all 0 and `lat_d` is unchanged.
  - On the last HOLD cycle edge: pulse `ack[w]` (and `err` if addr was out of range), clear `gnt`, set `ptr = (w+1) mod NREQ`, and go to IDLE.
- `lat_d` keeps its value in IDLE. It changes only on a grant edge.
- Requester inputs are sampled only on the grant edge. Later changes to addr or data are ignored.
- A `req` bit that drops mid-transaction does not abort the transaction; it still completes and acks.
- A requester that wants a second write keeps `req` high. After its `ack` it competes again, with lowest round-robin priority.

## Timing
- **Reset** (synchronous, takes priority over all other behaviour):
  - `gnt`, `ack`, `err`, `lat_en`, `busy` are 0; `lat_d` is 0.
  - State is IDLE and `ptr` is 0.
  - Reset in OPEN drops `lat_en` at the reset edge; latch contents are then unspecified.
- **Grant latency:** `gnt` is high in the cycle after `req` is first sampled high in IDLE.
- **`lat_en` timing:** the enable rises SETUP_CYC cycles after `gnt` rises and stays high OPEN_CYC cycles.
- **`ack` timing:** `ack` rises SETUP_CYC+OPEN_CYC+HOLD_CYC cycles after `gnt` rises, which is 4 with the defaults. `gnt` falls in the same cycle.
- **Back-to-back writes:**
  - The FSM spends at least one cycle in IDLE between transactions.
  - The minimum `lat_en` low gap between consecutive writes is therefore HOLD_CYC+1+SETUP_CYC cycles.
  - The minimum period is SETUP_CYC+OPEN_CYC+HOLD_CYC+1 cycles.
- **Invariants on every cycle:**
  - `popcount(lat_en)` ≤ 1 and `popcount(gnt)` ≤ 1.
  - `lat_d` is stable in every cycle where `lat_en` ≠ 0, and in the cycle before and after such cycles.
  - `busy` == (`gnt` ≠ 0).

## Test plan
- **Single write, defaults:** after reset, `req=0001`, addr0=2, data0=8'hA5.
  - `gnt=0001` for 4 cycles.
  - `lat_d=A5` from the grant cycle onward.
  - `lat_en=0100` for exactly 2 cycles, starting 1 cycle after grant.
  - `ack[0]` pulses 4 cycles after grant; `err=0`.
- **Round robin:** `req=1111` held; addr_i=i; data_i=8'h10+i.
  - Grant order is 0,1,2,3,0.
  - Each `ack` is 5 cycles apart.
  - `lat_en` walks 0001→0010→0100→1000.
  - `lat_en` is never high in two consecutive transactions without ≥3 low cycles between them.
- **Data change after grant:** requester 1 writes 8'h3C, then changes its data to 8'hFF one cycle after grant.
  - `lat_d` stays 3C through HOLD.
  - The next transaction shows FF.
- **Out-of-range address:** NLAT=3, addr=3.
  - `lat_en` stays 000 throughout.
  - `ack` and `err` pulse together.
- **Reset mid-OPEN:** assert `rst` in the first OPEN cycle.
  - Next cycle: `lat_en=0`, `gnt=0`, `busy=0`, no `ack`.
  - After release, `req=0010` is granted first (`ptr`=0 search finds 1).
- **Non-default timing:** SETUP_CYC=2, OPEN_CYC=3, HOLD_CYC=2.
  - `lat_en` is high 3 cycles, starting 2 cycles after grant.
  - `ack` arrives 7 cycles after grant.
  - The invariant checker passes over 1000 random-request cycles.

Source files
------------

// File: rtl/latch_bank_wr_ctrl.sv
// Round-robin write controller for a bank of level-sensitive latches.
// Each grant runs a setup / open / hold enable window on a shared data bus.
module latch_bank_wr_ctrl #(
    parameter  int NREQ      = 4,
    parameter  int DW        = 8,
    parameter  int NLAT      = 4,
    parameter  int SETUP_CYC = 1,
    parameter  int OPEN_CYC  = 2,
    parameter  int HOLD_CYC  = 1,
    localparam int AW        = $clog2(NLAT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      ack,
    output logic                 err,
    output logic [DW-1:0]        lat_d,
    output logic [NLAT-1:0]      lat_en,
    output logic                 busy
);
    localparam int IW   = $clog2(NREQ);
    localparam int MAXC = (SETUP_CYC > OPEN_CYC)
                        ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                        : ((OPEN_CYC > HOLD_CYC) ? OPEN_CYC : HOLD_CYC);
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [AW-1:0]   addr_reg;
    logic [IW-1:0]   win_reg;
    logic [IW-1:0]   ptr_reg;
    logic [NREQ-1:0] gnt_reg;
    logic [NREQ-1:0] ack_reg;
    logic            err_reg;
    logic [DW-1:0]   lat_d_reg;
    logic [NLAT-1:0] lat_en_reg;
    logic            busy_reg;

    logic [AW-1:0]   addr_arr [NREQ];
    logic [DW-1:0]   data_arr [NREQ];
    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0] req_rot;
    logic [IW-1:0]   off;
    logic [IW:0]     win_sum;
    logic [IW-1:0]   win_next;
    logic [NREQ-1:0] win_onehot;
    logic [IW:0]     ptr_sum;
    logic [IW-1:0]   ptr_next;
    logic [NLAT-1:0] en_dec;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign addr_arr[gi]   = req_addr[gi*AW +: AW];
            assign data_arr[gi]   = req_data[gi*DW +: DW];
            assign win_onehot[gi] = (win_next == IW'(gi));
        end
        // An out-of-range address matches no bit, so no enable ever fires for it.
        for (gi = 0; gi < NLAT; gi++) begin : g_lat
            assign en_dec[gi] = (addr_reg == AW'(gi));
        end
    endgenerate

    // Rotate requests so bit 0 is the requester at ptr, then take the lowest set bit.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr_reg +: NREQ];

    always_comb begin
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) off = IW'(k);
        end
    end

    assign win_sum  = {1'b0, ptr_reg} + {1'b0, off};
    assign win_next = (win_sum >= (IW+1)'(NREQ)) ? IW'(win_sum - (IW+1)'(NREQ)) : win_sum[IW-1:0];
    assign ptr_sum  = {1'b0, win_reg} + (IW+1)'(1);
    assign ptr_next = (ptr_sum >= (IW+1)'(NREQ)) ? '0 : ptr_sum[IW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            addr_reg   <= '0;
            win_reg    <= '0;
            ptr_reg    <= '0;
            gnt_reg    <= '0;
            ack_reg    <= '0;
            err_reg    <= 1'b0;
            lat_d_reg  <= '0;
            lat_en_reg <= '0;
            busy_reg   <= 1'b0;
        end else begin
            ack_reg <= '0;
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        win_reg   <= win_next;
                        addr_reg  <= addr_arr[win_next];
                        lat_d_reg <= data_arr[win_next];
                        gnt_reg   <= win_onehot;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= CW'(SETUP_CYC - 1);
                        state_reg <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_reg == '0) begin
                        lat_en_reg <= en_dec;
                        cnt_reg    <= CW'(OPEN_CYC - 1);
                        state_reg  <= OPEN;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                OPEN: begin
                    if (cnt_reg == '0) begin
                        lat_en_reg <= '0;
                        cnt_reg    <= CW'(HOLD_CYC - 1);
                        state_reg  <= HOLD;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_reg == '0) begin
                        ack_reg   <= gnt_reg;
                        err_reg   <= ~|en_dec;
                        gnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                        ptr_reg   <= ptr_next;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign gnt    = gnt_reg;
    assign ack    = ack_reg;
    assign err    = err_reg;
    assign lat_d  = lat_d_reg;
    assign lat_en = lat_en_reg;
    assign busy   = busy_reg;
endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// Bench for latch_bank_wr_ctrl: default instance with scoreboard and vector table,
// plus an NLAT=3 / 2-3-2 timing instance for out-of-range and random traffic.
module tb_latch_bank_wr_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Instance A: defaults
    logic        rst_a = 1'b1;
    logic [3:0]  req_a = '0;
    logic [7:0]  addr_a = '0;
    logic [31:0] data_a = '0;
    logic [3:0]  gnt_a, ack_a, en_a;
    logic        err_a, busy_a;
    logic [7:0]  d_a;

    // Instance B: NLAT=3, SETUP=2, OPEN=3, HOLD=2
    logic        rst_b = 1'b1;
    logic [3:0]  req_b = '0;
    logic [7:0]  addr_b = '0;
    logic [31:0] data_b = '0;
    logic [3:0]  gnt_b, ack_b;
    logic [2:0]  en_b;
    logic        err_b, busy_b;
    logic [7:0]  d_b;

    latch_bank_wr_ctrl u_a (
        .clk(clk), .rst(rst_a), .req(req_a), .req_addr(addr_a), .req_data(data_a),
        .gnt(gnt_a), .ack(ack_a), .err(err_a), .lat_d(d_a), .lat_en(en_a), .busy(busy_a)
    );

    latch_bank_wr_ctrl #(.NLAT(3), .SETUP_CYC(2), .OPEN_CYC(3), .HOLD_CYC(2)) u_b (
        .clk(clk), .rst(rst_b), .req(req_b), .req_addr(addr_b), .req_data(data_b),
        .gnt(gnt_b), .ack(ack_b), .err(err_b), .lat_d(d_b), .lat_en(en_b), .busy(busy_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard for instance A: one record per expected transaction, popped on ack.
    typedef struct {
        logic [3:0] gnt;
        logic [3:0] en;
        logic       err;
        logic [7:0] d;
    } exp_t;
    exp_t       q_a[$];
    exp_t       e_a;
    logic [3:0] en_acc_a = '0;

    always @(negedge clk) begin
        if (rst_a) begin
            q_a.delete();
            en_acc_a = '0;
        end else begin
            en_acc_a = en_acc_a | en_a;
            if (ack_a != 0) begin
                if (q_a.size() == 0) begin
                    chk("sb_unexpected_ack", ack_a, 0);
                end else begin
                    e_a = q_a.pop_front();
                    chk("sb_ack", ack_a, e_a.gnt);
                    chk("sb_err", err_a, e_a.err);
                    chk("sb_lat_en", en_acc_a, e_a.en);
                    chk("sb_lat_d", d_a, e_a.d);
                end
                en_acc_a = '0;
            end
        end
    end

    task automatic inv(input string tag, input logic [3:0] g, input logic [3:0] e, input logic b,
                       input logic [7:0] d, input logic [3:0] pe, input logic [7:0] pd,
                       input logic skip, input logic fell, input int low, input int min_gap);
        chk({tag, "_en_onehot"}, $countones(e) <= 1, 1);
        chk({tag, "_gnt_onehot"}, $countones(g) <= 1, 1);
        chk({tag, "_busy"}, b, g != 0);
        if (!skip && (e != 0 || pe != 0)) chk({tag, "_d_stable"}, d, pd);
        if (!skip && e != 0 && pe == 0 && fell) chk({tag, "_en_gap"}, low >= min_gap, 1);
    endtask

    logic [3:0] pen_a = '0, pen_b = '0;
    logic [7:0] pd_a = '0, pd_b = '0;
    logic       prst_a = 1'b1, prst_b = 1'b1;
    logic       fell_a = 1'b0, fell_b = 1'b0;
    int         low_a = 0, low_b = 0;

    always @(negedge clk) begin
        inv("a", gnt_a, en_a, busy_a, d_a, pen_a, pd_a, prst_a, fell_a, low_a, 3);
        if (en_a != 0) low_a = 0;
        else if (pen_a != 0) begin fell_a = 1'b1; low_a = 1; end
        else low_a++;
        pen_a = en_a; pd_a = d_a; prst_a = rst_a;
    end

    always @(negedge clk) begin
        inv("b", gnt_b, {1'b0, en_b}, busy_b, d_b, pen_b, pd_b, prst_b, fell_b, low_b, 5);
        if (en_b != 0) low_b = 0;
        else if (pen_b != 0) begin fell_b = 1'b1; low_b = 1; end
        else low_b++;
        pen_b = {1'b0, en_b}; pd_b = d_b; prst_b = rst_b;
    end

    task automatic wait_gnt_a(output int lat);
        lat = 0;
        do begin @(negedge clk); lat++; end while (gnt_a == 0 && lat < 8);
    endtask

    task automatic wait_gnt_b(output int lat);
        lat = 0;
        do begin @(negedge clk); lat++; end while (gnt_b == 0 && lat < 8);
    endtask

    task automatic drain_a();
        int c = 0;
        while (q_a.size() != 0 && c < 30) begin @(negedge clk); c++; end
        chk("a_drain", q_a.size(), 0);
    endtask

    task automatic reset_a();
        @(posedge clk); #1 rst_a = 1'b1; req_a = '0;
        @(posedge clk); @(posedge clk); #1 rst_a = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  gnt;
        logic [3:0]  en;
        logic [7:0]  d;
    } vec_t;
    vec_t       vecs[6];
    logic [3:0] order[5];
    int         lat, rises, acks, last_ack;
    logic [3:0] pg;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Each vector starts from the pointer left by the previous one (first ptr=1).
        vecs[0] = '{4'b1111, 8'hE4, 32'h44332211, 4'b0010, 4'b0010, 8'h22};
        vecs[1] = '{4'b1011, 8'hE4, 32'h44332211, 4'b1000, 4'b1000, 8'h44};
        vecs[2] = '{4'b0110, 8'h1B, 32'hDDCCBBAA, 4'b0010, 4'b0100, 8'hBB};
        vecs[3] = '{4'b0001, 8'h1B, 32'hDDCCBBAA, 4'b0001, 4'b1000, 8'hAA};
        vecs[4] = '{4'b1100, 8'h00, 32'h01020304, 4'b0100, 4'b0001, 8'h02};
        vecs[5] = '{4'b1100, 8'hFF, 32'h80706050, 4'b1000, 4'b1000, 8'h80};
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset values
        repeat (2) @(negedge clk);
        chk("a_rst_gnt", gnt_a, 0);
        chk("a_rst_ack", ack_a, 0);
        chk("a_rst_err", err_a, 0);
        chk("a_rst_en", en_a, 0);
        chk("a_rst_busy", busy_a, 0);
        chk("a_rst_d", d_a, 0);
        @(posedge clk); #1 rst_a = 1'b0;
        @(negedge clk);

        // Single write, defaults
        req_a = 4'b0001; addr_a = 8'h02; data_a = 32'h000000A5;
        q_a.push_back('{4'b0001, 4'b0100, 1'b0, 8'hA5});
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            chk("single_gnt", gnt_a, (k < 4) ? 4'b0001 : 4'b0000);
            chk("single_en", en_a, (k == 1 || k == 2) ? 4'b0100 : 4'b0000);
            chk("single_ack", ack_a, (k == 4) ? 4'b0001 : 4'b0000);
            chk("single_err", err_a, 0);
            chk("single_d", d_a, 8'hA5);
            if (k == 0) req_a = '0;
        end

        // Table vectors
        for (int i = 0; i < 6; i++) begin
            req_a = vecs[i].req; addr_a = vecs[i].addr; data_a = vecs[i].data;
            q_a.push_back('{vecs[i].gnt, vecs[i].en, 1'b0, vecs[i].d});
            wait_gnt_a(lat);
            chk("vec_latency", lat, 1);
            chk("vec_gnt", gnt_a, vecs[i].gnt);
            chk("vec_d", d_a, vecs[i].d);
            req_a = '0;
            drain_a();
        end

        // Round robin with all requests held
        reset_a();
        req_a = 4'b1111; addr_a = 8'hE4; data_a = 32'h13121110;
        q_a.push_back('{4'b0001, 4'b0001, 1'b0, 8'h10});
        q_a.push_back('{4'b0010, 4'b0010, 1'b0, 8'h11});
        q_a.push_back('{4'b0100, 4'b0100, 1'b0, 8'h12});
        q_a.push_back('{4'b1000, 4'b1000, 1'b0, 8'h13});
        q_a.push_back('{4'b0001, 4'b0001, 1'b0, 8'h10});
        rises = 0; acks = 0; last_ack = 0; pg = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (gnt_a != 0 && pg == 0) begin
                if (rises < 5) chk("rr_order", gnt_a, order[rises]);
                rises++;
                if (rises == 5) req_a = '0;
            end
            if (ack_a != 0) begin
                if (acks > 0) chk("rr_ack_gap", c - last_ack, 5);
                last_ack = c;
                acks++;
            end
            pg = gnt_a;
            if (rises >= 5 && q_a.size() == 0) break;
        end
        chk("rr_grants", rises, 5);
        chk("rr_acks", acks, 5);

        // Data change after grant; requester keeps req high for a second write
        req_a = 4'b0010; addr_a = 8'h04; data_a = 32'h00003C00;
        q_a.push_back('{4'b0010, 4'b0010, 1'b0, 8'h3C});
        q_a.push_back('{4'b0010, 4'b0010, 1'b0, 8'hFF});
        wait_gnt_a(lat);
        chk("chg_gnt", gnt_a, 4'b0010);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k <= 4) chk("chg_d_hold", d_a, 8'h3C);
            else begin
                chk("chg_d_next", d_a, 8'hFF);
                chk("chg_gnt2", gnt_a, 4'b0010);
                req_a = '0;
            end
            if (k == 1) data_a = 32'h0000FF00;
        end
        drain_a();

        // Reset during the first OPEN cycle
        req_a = 4'b0100; addr_a = 8'h00; data_a = 32'h00770000;
        wait_gnt_a(lat);
        chk("rmo_gnt", gnt_a, 4'b0100);
        req_a = '0;
        @(posedge clk); #1 rst_a = 1'b1;
        @(negedge clk);
        chk("rmo_open_en", en_a, 4'b0001);
        @(negedge clk);
        chk("rmo_en", en_a, 0);
        chk("rmo_gnt0", gnt_a, 0);
        chk("rmo_busy", busy_a, 0);
        chk("rmo_ack", ack_a, 0);
        @(posedge clk); #1 rst_a = 1'b0;
        req_a = 4'b1010; addr_a = 8'h0C; data_a = 32'h00009900;
        q_a.push_back('{4'b0010, 4'b1000, 1'b0, 8'h99});
        wait_gnt_a(lat);
        chk("rmo_latency", lat, 2);
        chk("rmo_first_gnt", gnt_a, 4'b0010);
        req_a = '0;
        drain_a();

        // Instance B: reset values, then non-default timing
        chk("b_rst_gnt", gnt_b, 0);
        chk("b_rst_en", en_b, 0);
        chk("b_rst_busy", busy_b, 0);
        @(posedge clk); #1 rst_b = 1'b0;
        @(negedge clk);
        req_b = 4'b0001; addr_b = 8'h01; data_b = 32'h0000005C;
        wait_gnt_b(lat);
        chk("b_latency", lat, 1);
        req_b = '0;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) @(negedge clk);
            chk("b_tim_gnt", gnt_b, (k < 7) ? 4'b0001 : 4'b0000);
            chk("b_tim_en", en_b, (k >= 2 && k <= 4) ? 3'b010 : 3'b000);
            chk("b_tim_ack", ack_b, (k == 7) ? 4'b0001 : 4'b0000);
            chk("b_tim_err", err_b, 0);
            chk("b_tim_d", d_b, 8'h5C);
        end

        // Out-of-range address on NLAT=3
        req_b = 4'b0010; addr_b = 8'h0C; data_b = 32'h0000E100;
        wait_gnt_b(lat);
        chk("oor_gnt_first", gnt_b, 4'b0010);
        req_b = '0;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) @(negedge clk);
            chk("oor_gnt", gnt_b, (k < 7) ? 4'b0010 : 4'b0000);
            chk("oor_en", en_b, 0);
            chk("oor_ack", ack_b, (k == 7) ? 4'b0010 : 4'b0000);
            chk("oor_err", err_b, k == 7);
            chk("oor_d", d_b, 8'hE1);
        end

        // Random requests; invariant monitors check every cycle
        for (int c = 0; c < 1000; c++) begin
            req_b  = 4'($urandom_range(0, 15));
            addr_b = 8'($urandom);
            data_b = $urandom;
            @(negedge clk);
            chk("rand_err_with_ack", err_b && (ack_b == 0), 0);
        end
        req_b = '0;
        repeat (12) @(negedge clk);
        chk("rand_idle", busy_b, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
